button_debouncer: RTL
=====================

# button_debouncer

Debounces one mechanical push-button input for the button-controller design. A four-state FSM drives two chained modulo counters and acts on their rollovers: a prescaler that generates ticks, and a tick counter that measures stability. The block emits a clean level plus one-cycle press and release strobes for downstream control logic.

## Interface
- `TICK_DIV`, default 100000: clock cycles per debounce tick (≥1).
- `DEBOUNCE_TICKS`, default 5: consecutive stable ticks required to accept a level change (≥1).
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_in`  in  1  raw button level, possibly asynchronous and bouncing.
- `debounced`  out  1  accepted button level, registered.
- `press_pulse`  out  1  one-cycle strobe on accepted 0→1.
- `release_pulse`  out  1  one-cycle strobe on accepted 1→0.

## Operation
- `s_in`: the sampled input. It comes from the synchronizer when that is compiled in, otherwise it is `btn_in` directly.
- States:
  - LOW: if `s_in`=1, go to WAIT_HIGH.
  - WAIT_HIGH: if `s_in`=0, go to LOW. On final rollover with `s_in`=1, go to HIGH.
  - HIGH: if `s_in`=0, go to WAIT_LOW.
  - WAIT_LOW: if `s_in`=1, go to HIGH. On final rollover with `s_in`=0, go to LOW.
- Prescaler:
  - Counts 0..TICK_DIV-1, enabled only in the WAIT states.
  - Rollover is `tick`.
  - Synchronously cleared in LOW and HIGH.
- Tick counter:
  - Counts 0..DEBOUNCE_TICKS-1, incremented on `tick`.
  - Its rollover is the "final rollover".
  - Cleared together with the prescaler.
- Counter widths: $clog2(TICK_DIV) and $clog2(DEBOUNCE_TICKS), with a minimum of 1 bit each. Both counters wrap to 0 on rollover.
- `debounced` is 1 in HIGH and WAIT_LOW, and 0 in LOW and WAIT_HIGH.
- `press_pulse` is 1 for exactly the one cycle after the WAIT_HIGH→HIGH transition. `release_pulse` is likewise 1 for the one cycle after WAIT_LOW→LOW. The two strobes are never high together.
- Abort priority: if `s_in` reverts in the same cycle as the final rollover, the abort wins. The FSM returns to its prior stable state, no strobe fires, and both counters clear.
- Any glitch during a WAIT state restarts the full debounce interval from zero on the next re-entry.

## Timing
- Reset values: state LOW, `debounced`=0, `press_pulse`=0, `release_pulse`=0, both counters 0, synchronizer flops 0.
- Reset asserted mid-WAIT abandons the measurement. No strobe is emitted.
- If `s_in`=1 at cycle C while in LOW, the FSM is in WAIT_HIGH at C+1.
- If `s_in` then stays 1, the final rollover occurs at cycle C+TICK_DIV·DEBOUNCE_TICKS. `debounced` rises and `press_pulse`=1 at C+1+TICK_DIV·DEBOUNCE_TICKS.
- The release path is symmetric.
- TICK_DIV=1: `tick` is asserted every cycle spent in a WAIT state.
- DEBOUNCE_TICKS=1: the first tick is the final rollover.
- If the button is held high through reset release, the FSM goes LOW→WAIT_HIGH→HIGH and emits `press_pulse` once.

## Configuration
- `BUTTON_DEBOUNCER_SYNC_EN` defined:
  - `btn_in` passes through a two-flop synchronizer reset to 0.
  - `s_in` lags `btn_in` by 2 cycles, so all latencies above grow by 2.
- `BUTTON_DEBOUNCER_SYNC_EN` undefined:
  - `s_in` = `btn_in` combinationally.
  - `btn_in` must already be synchronous to `clk`.

## Structure
- Package `button_debouncer_pkg` holds `debounce_state_t`, a 2-bit enum of LOW, WAIT_HIGH, HIGH, WAIT_LOW.
- Sub-module `mod_counter` (parameters MOD_VALUE, BIT_WIDTH; ports clk, reset, increment, rolling_over, count) is instantiated twice:
  - Prescaler: increment = in-WAIT, and its reset input = `reset` OR not-in-WAIT.
  - Tick counter: increment = `tick`, with the same reset input.
- FSM and output registers live in the top module.

## Test plan
Run with TICK_DIV=4 and DEBOUNCE_TICKS=3 (12-cycle interval), synchronizer off unless stated.
- Clean press: `btn_in` 0→1 at cycle 10 and held → `debounced`=1 and `press_pulse`=1 at cycle 23 only; `release_pulse` stays 0.
- Bounce: `btn_in` toggles every 3 cycles for 30 cycles, then holds 1 → no strobe during bounce; `debounced` rises exactly 13 cycles after the last 0→1 edge.
- Abort race: `btn_in` high at cycle 10 and dropped at cycle 22 (final rollover cycle) → FSM returns to LOW at 23; `debounced` stays 0; no strobe.
- Release: from HIGH, `btn_in` 1→0 at cycle 50 and held → `debounced`=0 and `release_pulse`=1 at cycle 63 only.
- Reset mid-WAIT: assert `reset` at cycle 15 of a press that started at cycle 10 → all outputs 0 at 16. With `btn_in` still 1 after release at cycle 17, `press_pulse` fires at cycle 30.
- Synchronizer on (`BUTTON_DEBOUNCER_SYNC_EN`): repeat the clean press → strobe at cycle 25.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for the push-button debouncer.
package button_debouncer_pkg;

  // The two stable levels, each paired with a WAIT state that measures
  // whether a requested change of level holds for long enough.
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } debounce_state_t;

  // Width of a counter running 0..modulus-1. Always at least 1 bit, so a
  // modulus of 1 still yields a legal vector.
  function automatic int counter_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD_VALUE up-counter with a synchronous clear. rolling_over is
// high in the cycle an increment moves the count from MOD_VALUE-1 back to 0.
module mod_counter #(
  parameter int MOD_VALUE = 2,
  parameter int BIT_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 increment,
  output logic                 rolling_over,
  output logic [BIT_WIDTH-1:0] count
);

  localparam logic [BIT_WIDTH-1:0] LAST = BIT_WIDTH'(MOD_VALUE - 1);

  assign rolling_over = increment && (count == LAST);

  // Count on increment, wrapping to zero at the terminal value.
  // NOTE: state registers use non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (rolling_over) begin
      count <= '0;
    end else if (increment) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: a four-state FSM gates a tick prescaler and a
// stability counter, and accepts a level change only after DEBOUNCE_TICKS
// consecutive ticks of an unchanged input.
// Optional feature: define BUTTON_DEBOUNCER_SYNC_EN to insert a two-flop
// synchronizer on btn_in (adds two cycles of latency).
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int TICK_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic debounced,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int PRE_W  = counter_width(TICK_DIV);
  localparam int TICK_W = counter_width(DEBOUNCE_TICKS);

  logic s_in;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
  logic sync_meta;
  logic sync_out;

  // Two-flop synchronizer bringing the raw button into the clk domain.
  // NOTE: these flops are reset so s_in is a known 0 immediately after
  // reset rather than whatever level the pin held beforehand.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      sync_out  <= sync_meta;
    end
  end

  assign s_in = sync_out;
`else
  assign s_in = btn_in;
`endif

  debounce_state_t   state;
  logic              in_wait;
  logic              counter_clear;
  logic              tick;
  logic              final_rollover;
  logic [PRE_W-1:0]  pre_count;
  logic [TICK_W-1:0] tick_count;

  // Counters only run while a level change is being measured; leaving a
  // WAIT state (accept or abort) clears them so every attempt starts at 0.
  assign in_wait       = (state == WAIT_HIGH) || (state == WAIT_LOW);
  assign counter_clear = reset || !in_wait;

  mod_counter #(
    .MOD_VALUE (TICK_DIV),
    .BIT_WIDTH (PRE_W)
  ) u_prescaler (
    .clk          (clk),
    .reset        (counter_clear),
    .increment    (in_wait),
    .rolling_over (tick),
    .count        (pre_count)
  );

  mod_counter #(
    .MOD_VALUE (DEBOUNCE_TICKS),
    .BIT_WIDTH (TICK_W)
  ) u_tick_counter (
    .clk          (clk),
    .reset        (counter_clear),
    .increment    (tick),
    .rolling_over (final_rollover),
    .count        (tick_count)
  );

  // The raw counts are only of interest when probing the design.
  logic unused_counts;
  assign unused_counts = ^{pre_count, tick_count};

  // FSM with registered level and strobes; an input reversal beats a
  // coincident final rollover, so a late glitch never yields a strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LOW;
      debounced     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        LOW: begin
          if (s_in) state <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (!s_in) begin
            state <= LOW;
          end else if (final_rollover) begin
            state       <= HIGH;
            debounced   <= 1'b1;
            press_pulse <= 1'b1;
          end
        end
        HIGH: begin
          if (!s_in) state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (s_in) begin
            state <= HIGH;
          end else if (final_rollover) begin
            state         <= LOW;
            debounced     <= 1'b0;
            release_pulse <= 1'b1;
          end
        end
        default: state <= LOW;
      endcase
    end
  end

endmodule
